// File: rtl/tone_div_engine.sv
// Button-driven volume/octave registers plus a round-robin sequential divider that
// turns each channel's tone frequency into a note_gen clock divisor CLK_HZ/fe.

module tone_div_btn #(
    parameter int MIN  = 1,
    parameter int MAX  = 5,
    parameter int INIT = 3,
    parameter int DLY  = 25000000,
    parameter int PER  = 10000000,
    parameter int W    = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_up,
    input  logic         i_down,
    output logic [W-1:0] o_val
);
    localparam int CNT_W = $clog2(DLY + 1);

    logic             r_up_q, r_dn_q;
    logic [CNT_W-1:0] r_up_cnt, r_dn_cnt;
    logic [W-1:0]     r_val;
    logic             w_step_up, w_step_dn;

    // A step fires on the press edge, then once the held-cycle count reaches DLY,
    // then every PER cycles; counters reload to DLY-PER to produce the period.
    always_comb begin
        w_step_up = 1'b0;
        w_step_dn = 1'b0;
        if (i_up && !i_down)
            w_step_up = !r_up_q || (r_up_cnt == CNT_W'(DLY - 1));
        if (i_down && !i_up)
            w_step_dn = !r_dn_q || (r_dn_cnt == CNT_W'(DLY - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_up_q   <= 1'b0;
            r_dn_q   <= 1'b0;
            r_up_cnt <= '0;
            r_dn_cnt <= '0;
            r_val    <= W'(INIT);
        end else begin
            r_up_q <= i_up;
            r_dn_q <= i_down;
            if (i_up && i_down) begin
                r_up_cnt <= '0;
                r_dn_cnt <= '0;
            end else begin
                if (!i_up)                             r_up_cnt <= '0;
                else if (!r_up_q)                      r_up_cnt <= CNT_W'(1);
                else if (r_up_cnt == CNT_W'(DLY - 1))  r_up_cnt <= CNT_W'(DLY - PER);
                else                                   r_up_cnt <= r_up_cnt + CNT_W'(1);
                if (!i_down)                           r_dn_cnt <= '0;
                else if (!r_dn_q)                      r_dn_cnt <= CNT_W'(1);
                else if (r_dn_cnt == CNT_W'(DLY - 1))  r_dn_cnt <= CNT_W'(DLY - PER);
                else                                   r_dn_cnt <= r_dn_cnt + CNT_W'(1);
            end
            if (w_step_up && (r_val < W'(MAX)))
                r_val <= r_val + W'(1);
            else if (w_step_dn && (r_val > W'(MIN)))
                r_val <= r_val - W'(1);
        end
    end

    assign o_val = r_val;
endmodule

module tone_div_engine #(
    parameter int CHANNELS   = 2,
    parameter int FREQ_W     = 32,
    parameter int DIV_W      = 22,
    parameter int CLK_HZ     = 50000000,
    parameter int VOL_MAX    = 5,
    parameter int VOL_INIT   = 3,
    parameter int OCT_MIN    = 1,
    parameter int OCT_MAX    = 3,
    parameter int OCT_INIT   = 2,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_vol_up,
    input  logic                        i_vol_down,
    input  logic                        i_oct_up,
    input  logic                        i_oct_down,
    input  logic                        i_mute,
    input  logic                        i_enable,
    input  logic [CHANNELS*FREQ_W-1:0]  i_freq_in,
    output logic [2:0]                  o_volume,
    output logic [2:0]                  o_octave,
    output logic [CHANNELS*DIV_W-1:0]   o_note_div,
    output logic [CHANNELS-1:0]         o_div_upd,
    output logic                        o_busy
);
    localparam int CW     = $clog2(CLK_HZ + 1);
    localparam int CNTW   = $clog2(CW + 1);
    localparam int CHW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int UP_MAX = (OCT_MAX > OCT_INIT) ? OCT_MAX - OCT_INIT : 0;
    localparam int WW     = FREQ_W + UP_MAX;

    typedef enum logic [1:0] {S_SCAN, S_DIV, S_WRITE} state_t;

    state_t                           r_state, w_next;
    logic [CHW-1:0]                   r_ch;
    logic [CHANNELS-1:0][DIV_W-1:0]   r_div;
    logic [CHANNELS-1:0]              r_upd;
    logic [FREQ_W-1:0]                r_dsr, r_rem;
    logic [CW-1:0]                    r_dvd, r_quo;
    logic [CNTW-1:0]                  r_cnt;

    logic [CHANNELS-1:0][FREQ_W-1:0]  w_freq;
    logic [FREQ_W-1:0]                w_f, w_fe, w_rem_nxt;
    logic [WW-1:0]                    w_wide;
    logic [FREQ_W:0]                  w_trial;
    logic                             w_ge, w_silent;
    logic [DIV_W-1:0]                 w_q_sat;
    logic [CHW-1:0]                   w_ch_nxt;
    logic [CHANNELS-1:0]              w_onehot;

    tone_div_btn #(.MIN(1), .MAX(VOL_MAX), .INIT(VOL_INIT), .DLY(REPEAT_DLY),
                   .PER(REPEAT_PER), .W(3)) u_vol (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_up(i_vol_up), .i_down(i_vol_down), .o_val(o_volume));

    tone_div_btn #(.MIN(OCT_MIN), .MAX(OCT_MAX), .INIT(OCT_INIT), .DLY(REPEAT_DLY),
                   .PER(REPEAT_PER), .W(3)) u_oct (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_up(i_oct_up), .i_down(i_oct_down), .o_val(o_octave));

    assign w_freq = i_freq_in;
    assign w_f    = w_freq[r_ch];

    // Octave scaling; upward shifts clamp rather than lose high bits.
    always_comb begin
        w_wide = '0;
        w_fe   = w_f;
        if (int'(o_octave) > OCT_INIT) begin
            w_wide = WW'(w_f) << (int'(o_octave) - OCT_INIT);
            w_fe   = ((w_wide >> FREQ_W) != '0) ? '1 : w_wide[FREQ_W-1:0];
        end else if (int'(o_octave) < OCT_INIT) begin
            w_fe = w_f >> (OCT_INIT - int'(o_octave));
        end
    end

    assign w_silent  = i_mute || !i_enable || (w_fe == '0);
    assign w_trial   = {r_rem, r_dvd[CW-1]};
    assign w_ge      = (w_trial >= {1'b0, r_dsr});
    assign w_rem_nxt = w_ge ? FREQ_W'(w_trial - {1'b0, r_dsr}) : w_trial[FREQ_W-1:0];
    assign w_q_sat   = ((r_quo >> DIV_W) != '0) ? '1 : DIV_W'(r_quo);
    assign w_ch_nxt  = (r_ch == CHW'(CHANNELS - 1)) ? '0 : r_ch + CHW'(1);
    assign w_onehot  = CHANNELS'(1) << r_ch;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_SCAN;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SCAN:  if (!w_silent) w_next = S_DIV;
            S_DIV:   if (r_cnt == CNTW'(CW - 1)) w_next = S_WRITE;
            S_WRITE: w_next = S_SCAN;
            default: w_next = S_SCAN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ch  <= '0;
            r_upd <= '0;
            r_dsr <= '0;
            r_rem <= '0;
            r_dvd <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            for (int k = 0; k < CHANNELS; k++) r_div[k] <= DIV_W'(1);
        end else begin
            r_upd <= '0;
            case (r_state)
                S_SCAN: begin
                    if (w_silent) begin
                        r_div[r_ch] <= DIV_W'(1);
                        r_upd       <= w_onehot;
                        r_ch        <= w_ch_nxt;
                    end else begin
                        r_dsr <= w_fe;
                        r_rem <= '0;
                        r_dvd <= CW'(CLK_HZ);
                        r_quo <= '0;
                        r_cnt <= '0;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[CW-2:0], 1'b0};
                    r_quo <= {r_quo[CW-2:0], w_ge};
                    r_cnt <= r_cnt + CNTW'(1);
                end
                S_WRITE: begin
                    r_div[r_ch] <= w_q_sat;
                    r_upd       <= w_onehot;
                    r_ch        <= w_ch_nxt;
                end
                default: ;
            endcase
        end
    end

    assign o_note_div = r_div;
    assign o_div_upd  = r_upd;
    assign o_busy     = (r_state == S_DIV);
endmodule

// File: tb/tb_tone_div_engine.sv
// Directed bench for tone_div_engine: divisor values, octave/volume saturation,
// mute/enable silencing, hold-to-repeat timing and asynchronous reset.

module tb_tone_div_engine;
    localparam int LAT = 112;

    logic        clk, rst_n;
    logic        vol_up, vol_down, oct_up, oct_down, mute, enable;
    logic [31:0] f0, f1;
    logic [2:0]  volume, octave;
    logic [43:0] note_div;
    logic [1:0]  div_upd;
    logic        busy;
    logic [1:0]  seen;
    int          n_checks, n_err;

    tone_div_engine #(.REPEAT_DLY(100), .REPEAT_PER(20)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_vol_up(vol_up), .i_vol_down(vol_down),
        .i_oct_up(oct_up), .i_oct_down(oct_down),
        .i_mute(mute), .i_enable(enable),
        .i_freq_in({f1, f0}),
        .o_volume(volume), .o_octave(octave),
        .o_note_div(note_div), .o_div_upd(div_upd), .o_busy(busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            seen = seen | div_upd;
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            0: oct_up   = 1'b1;
            1: oct_down = 1'b1;
            2: vol_down = 1'b1;
            default: vol_up = 1'b1;
        endcase
        cyc(2);
        oct_up = 1'b0; oct_down = 1'b0; vol_down = 1'b0; vol_up = 1'b0;
        cyc(2);
    endtask

    initial begin
        n_checks = 0; n_err = 0; seen = '0;
        rst_n = 1'b0; vol_up = 0; vol_down = 0; oct_up = 0; oct_down = 0;
        mute = 0; enable = 1; f0 = 440; f1 = 262;
        cyc(2);
        check("rst_div0", {10'd0, note_div[21:0]}, 1);
        check("rst_div1", {10'd0, note_div[43:22]}, 1);
        check("rst_upd", {30'd0, div_upd}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_vol", {29'd0, volume}, 3);
        check("rst_oct", {29'd0, octave}, 2);

        rst_n = 1'b1;
        cyc(LAT);
        check("t1_div0", {10'd0, note_div[21:0]}, 113636);
        check("t1_div1", {10'd0, note_div[43:22]}, 190839);

        pulse(0);
        check("t2_oct_up", {29'd0, octave}, 3);
        cyc(LAT);
        check("t2_div0", {10'd0, note_div[21:0]}, 56818);
        check("t2_div1", {10'd0, note_div[43:22]}, 95419);
        pulse(0);
        check("t2_oct_sat", {29'd0, octave}, 3);
        cyc(LAT);
        check("t2_div0_hold", {10'd0, note_div[21:0]}, 56818);

        pulse(1); pulse(1);
        check("t3_oct_dn", {29'd0, octave}, 1);
        cyc(LAT);
        check("t3_div1", {10'd0, note_div[43:22]}, 381679);
        check("t3_div0", {10'd0, note_div[21:0]}, 227272);
        pulse(1);
        check("t3_oct_sat", {29'd0, octave}, 1);

        begin
            int t = 0;
            while (!busy && t < 60) begin cyc(1); t++; end
            check("t4_busy_seen", {31'd0, busy}, 1);
        end
        mute = 1'b1; seen = '0;
        cyc(LAT);
        check("t4_mute_div0", {10'd0, note_div[21:0]}, 1);
        check("t4_mute_div1", {10'd0, note_div[43:22]}, 1);
        check("t4_upd_seen", {30'd0, seen}, 3);
        mute = 1'b0;
        cyc(LAT);
        check("t4_rest_div0", {10'd0, note_div[21:0]}, 227272);
        check("t4_rest_div1", {10'd0, note_div[43:22]}, 381679);
        enable = 1'b0;
        cyc(LAT);
        check("t4_pause_div0", {10'd0, note_div[21:0]}, 1);
        enable = 1'b1;

        pulse(0);
        check("t5_oct", {29'd0, octave}, 2);
        f0 = 5;
        cyc(LAT);
        check("t5_sat_div0", {10'd0, note_div[21:0]}, 4194303);
        check("t5_div1", {10'd0, note_div[43:22]}, 190839);
        f0 = 0;
        cyc(LAT);
        check("t5_zero_div0", {10'd0, note_div[21:0]}, 1);
        vol_up = 1'b1; vol_down = 1'b1;
        cyc(3);
        vol_up = 1'b0; vol_down = 1'b0;
        cyc(2);
        check("t5_vol_both", {29'd0, volume}, 3);

        pulse(2); pulse(2);
        check("t6_vol_min", {29'd0, volume}, 1);
        pulse(2);
        check("t6_vol_min_sat", {29'd0, volume}, 1);
        vol_up = 1'b1;
        cyc(1);   check("t6_step1", {29'd0, volume}, 2);
        cyc(98);  check("t6_pre_rep", {29'd0, volume}, 2);
        cyc(1);   check("t6_rep1", {29'd0, volume}, 3);
        cyc(19);  check("t6_pre_rep2", {29'd0, volume}, 3);
        cyc(1);   check("t6_rep2", {29'd0, volume}, 4);
        cyc(20);  check("t6_rep3", {29'd0, volume}, 5);
        cyc(60);  check("t6_vol_max", {29'd0, volume}, 5);

        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_vol", {29'd0, volume}, 3);
        check("t6_rst_div0", {10'd0, note_div[21:0]}, 1);
        check("t6_rst_div1", {10'd0, note_div[43:22]}, 1);
        check("t6_rst_busy", {31'd0, busy}, 0);
        vol_up = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
